// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, round constants and byte-level helpers.
package aes_pkg;

    localparam int unsigned AES_NUM_ROUNDS = 10;
    localparam int unsigned AES_WORD_W     = 32;
    localparam int unsigned AES_KEY_W      = 128;
    localparam int unsigned AES_IDX_W      = 4;

    typedef logic [AES_WORD_W-1:0] aes_word_t;
    typedef logic [AES_KEY_W-1:0]  aes_key_t;

    // Entry 0 is the constant for round 1.
    localparam logic [7:0] AES_RCON [AES_NUM_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] inv;
        y   = x;
        inv = 8'h01;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gf_mul(inv, y);
            y = gf_mul(y, y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
    endfunction

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load and round-key read bus between the key schedule and the cipher pipeline.
interface aes_key_schedule_if;
    import aes_pkg::*;

    logic                 start;
    aes_key_t             key_in;
    logic                 busy;
    logic                 key_valid;
    logic [AES_IDX_W-1:0] rd_idx;
    aes_key_t             rd_key;

    modport master (
        output start, key_in, rd_idx,
        input  busy, key_valid, rd_key
    );

    modport slave (
        input  start, key_in, rd_idx,
        output busy, key_valid, rd_key
    );

endinterface

// File: rtl/aes_key_expand_round.sv
// One AES-128 key-expansion round: previous round key in, next round key out.
module aes_key_expand_round
    import aes_pkg::*;
(
    input  aes_key_t             prev_key,
    input  logic [AES_IDX_W-1:0] round_idx,
    output aes_key_t             next_key
);

    aes_word_t  w0, w1, w2, w3;
    aes_word_t  t, n0, n1, n2, n3;
    logic [7:0] rcon;
    logic [AES_IDX_W-1:0] rcon_sel;

    assign {w0, w1, w2, w3} = prev_key;
    assign rcon_sel         = round_idx - 4'd1;

    // Out-of-range round indices contribute no round constant.
    always_comb begin
        rcon = 8'h00;
        if (round_idx >= 4'd1 && round_idx <= 4'(AES_NUM_ROUNDS)) begin
            rcon = AES_RCON[rcon_sel];
        end
    end

    assign t  = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: one expansion round per clock into an 11-slot buffer.
// Define AES_KEY_SCHED_RESTART_EN to let start during expansion restart with the new key.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input logic              clk,
    input logic              rst,
    aes_key_schedule_if.slave bus
);

    localparam int unsigned NUM_SLOTS = NUM_ROUNDS + 1;
    localparam logic [AES_IDX_W-1:0] LAST_RC = AES_IDX_W'(NUM_ROUNDS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    logic [1:0]           state, state_nxt;
    logic [AES_IDX_W-1:0] rc, rc_nxt;
    logic                 load, step;

    aes_key_t             work;
    aes_key_t             next_key;
    aes_key_t             slots [NUM_SLOTS];

    logic                 busy, key_valid;
    aes_key_t             rd_key;

    aes_key_expand_round u_round (
        .prev_key  (work),
        .round_idx (rc),
        .next_key  (next_key)
    );

    // Next-state and datapath-enable decode.
    always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE, ST_READY: begin
                if (bus.start) begin
                    state_nxt = ST_EXPAND;
                    rc_nxt    = 4'd1;
                    load      = 1'b1;
                end
            end
            ST_EXPAND: begin
`ifdef AES_KEY_SCHED_RESTART_EN
                if (bus.start) begin
                    rc_nxt = 4'd1;
                    load   = 1'b1;
                end else begin
                    step   = 1'b1;
                    rc_nxt = rc + 4'd1;
                    if (rc == LAST_RC) state_nxt = ST_READY;
                end
`else
                step   = 1'b1;
                rc_nxt = rc + 4'd1;
                if (rc == LAST_RC) state_nxt = ST_READY;
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
                rc_nxt    = '0;
            end
        endcase
    end

    // Control state and registered outputs; reads are masked unless the schedule is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rc        <= '0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            rd_key    <= '0;
        end else begin
            state     <= state_nxt;
            rc        <= rc_nxt;
            busy      <= (state_nxt == ST_EXPAND);
            key_valid <= (state_nxt == ST_READY);
            if (key_valid && bus.rd_idx <= LAST_RC) rd_key <= slots[bus.rd_idx];
            else                                    rd_key <= '0;
        end
    end

    // Working register and key buffer carry no reset; key_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && load) begin
            work     <= bus.key_in;
            slots[0] <= bus.key_in;
        end else if (!rst && step) begin
            work      <= next_key;
            slots[rc] <= next_key;
        end
    end

    assign bus.busy      = busy;
    assign bus.key_valid = key_valid;
    assign bus.rd_key    = rd_key;

endmodule
